// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, and presents fetched words in a registered IF/OF slot.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic        of_ready,
    output logic        of_valid,
    output logic [31:0] of_pc,
    output logic [31:0] of_instruction
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // Handshake: the slot transfers to operand fetch on a cycle where
    // of_valid && of_ready; its contents stay stable while of_valid && !of_ready.
    // imem_req/imem_addr stay stable from the first request cycle until imem_valid.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        of_valid_q, of_valid_d;
    logic [31:0] of_pc_q, of_pc_d;
    logic [31:0] of_instr_q, of_instr_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic slot_free;
    logic resp_pending;

    assign slot_free    = !of_valid_q || of_ready;
    // A request is still outstanding past this edge when we are asking and
    // the memory has not answered yet.
    assign resp_pending = (state_q == ST_REQ || state_q == ST_DRAIN) && !imem_valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        of_valid_d   = of_valid_q;
        of_pc_d      = of_pc_q;
        of_instr_d   = of_instr_q;
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;

        if (of_valid_q && of_ready) begin
            of_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_REQ: begin
                if (imem_valid) begin
                    pc_d = pc_q + 32'd4;
                    if (slot_free) begin
                        of_valid_d = 1'b1;
                        of_pc_d    = pc_q;
                        of_instr_d = imem_rdata;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_rdata;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!hold_valid_q) begin
                    state_d = ST_REQ;
                end else if (of_ready) begin
                    of_valid_d   = 1'b1;
                    of_pc_d      = hold_pc_q;
                    of_instr_d   = hold_instr_q;
                    hold_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // A redirect overrides everything: the slot and hold entry are on the
        // wrong path, and an unanswered request must be drained at its old address.
        if (branch_taken) begin
            pc_d         = branch_pc & ALIGN_MASK;
            of_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            state_d      = resp_pending ? ST_DRAIN : ST_REQ;
            if (state_q == ST_REQ && !imem_valid) begin
                drain_addr_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC & ALIGN_MASK;
            drain_addr_q <= 32'd0;
            of_valid_q   <= 1'b0;
            of_pc_q      <= 32'd0;
            of_instr_q   <= 32'd0;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= 32'd0;
            hold_instr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            of_valid_q   <= of_valid_d;
            of_pc_q      <= of_pc_d;
            of_instr_q   <= of_instr_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Request is gated by rst_n so nothing is issued while reset is held.
    assign imem_req       = rst_n && (state_q == ST_REQ || state_q == ST_DRAIN);
    assign imem_addr      = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign of_valid       = of_valid_q;
    assign of_pc          = of_pc_q;
    assign of_instruction = of_instr_q;

endmodule
